ristretto_alu_mc: RTL and testbench

- Multi-cycle, handshaked execute-stage ALU, successor to the single-cycle combinational ALU.
- Adds signed/unsigned set-less-than, logical/arithmetic shifts via an iterative shifter (ShiftPerCycle bits per cycle), a real signed-overflow flag, and registered results.
- Sits between decode/issue (valid/ready in) and writeback (valid/ready out); a kill input flushes an in-flight operation.

---
 rtl/ristretto_alu_mc.sv | 205 ++++++++++++++++++++
 tb/tb_ristretto_alu_mc.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ristretto_alu_mc.sv
// Multi-cycle execute-stage ALU: single-cycle arithmetic/logic, iterative shifter,
// registered result and flags. valid/ready on both sides, kill flushes the in-flight op.
module ristretto_alu_mc #(
    parameter int DataWidth     = 32,
    parameter int ShiftPerCycle = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [3:0]           op_i,
    input  logic [DataWidth-1:0] operand_a_i,
    input  logic [DataWidth-1:0] operand_b_i,
    input  logic                 kill_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [DataWidth-1:0] result_o,
    output logic                 zero_o,
    output logic                 negative_o,
    output logic                 overflow_o
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both
    // high; the producer holds its payload stable until then, and kill_i outranks both.

    localparam int SW = $clog2(DataWidth);
    localparam logic [SW:0] LP_STEP = (SW+1)'(ShiftPerCycle);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLT  = 4'd5;
    localparam logic [3:0] OP_SLTU = 4'd6;
    localparam logic [3:0] OP_SLL  = 4'd7;
    localparam logic [3:0] OP_SRL  = 4'd8;
    localparam logic [3:0] OP_SRA  = 4'd9;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [DataWidth-1:0] r_acc;
    logic [SW-1:0]        r_rem;
    logic [3:0]           r_kind;
    logic                 r_pend_z;
    logic                 r_pend_n;
    logic                 r_pend_v;

    logic [DataWidth-1:0] w_sum;
    logic [DataWidth-1:0] w_diff;
    logic                 w_lt_s;
    logic                 w_lt_u;
    logic                 w_ovf_add;
    logic                 w_ovf_sub;
    logic [DataWidth-1:0] w_result;
    logic                 w_flag_z;
    logic                 w_flag_n;
    logic                 w_flag_v;
    logic                 w_is_shift;
    logic [SW-1:0]        w_shamt;
    logic                 w_take;
    logic                 w_start_shift;
    logic [SW:0]          w_step;
    logic [SW:0]          w_rem_next;
    logic                 w_shift_last;
    logic [DataWidth-1:0] w_shifted;

    assign w_sum     = operand_a_i + operand_b_i;
    assign w_diff    = operand_a_i - operand_b_i;
    assign w_lt_s    = $signed(operand_a_i) < $signed(operand_b_i);
    assign w_lt_u    = operand_a_i < operand_b_i;
    assign w_ovf_add = (operand_a_i[DataWidth-1] == operand_b_i[DataWidth-1]) &&
                       (w_sum[DataWidth-1] != operand_a_i[DataWidth-1]);
    assign w_ovf_sub = (operand_a_i[DataWidth-1] != operand_b_i[DataWidth-1]) &&
                       (w_diff[DataWidth-1] != operand_a_i[DataWidth-1]);

    assign w_is_shift = (op_i == OP_SLL) || (op_i == OP_SRL) || (op_i == OP_SRA);
    assign w_shamt    = operand_b_i[SW-1:0];

    // Shifts with a zero amount fall through to the PASS_A result.
    always_comb begin
        w_result = operand_a_i;
        case (op_i)
            OP_ADD:  w_result = w_sum;
            OP_SUB:  w_result = w_diff;
            OP_AND:  w_result = operand_a_i & operand_b_i;
            OP_OR:   w_result = operand_a_i | operand_b_i;
            OP_XOR:  w_result = operand_a_i ^ operand_b_i;
            OP_SLT:  w_result = {{(DataWidth-1){1'b0}}, w_lt_s};
            OP_SLTU: w_result = {{(DataWidth-1){1'b0}}, w_lt_u};
            default: w_result = operand_a_i;
        endcase
    end

    assign w_flag_z = (operand_a_i == operand_b_i);
    assign w_flag_n = ((op_i == OP_SLTU) || (op_i == OP_SRL)) ? w_lt_u : w_lt_s;
    assign w_flag_v = (op_i == OP_ADD) ? w_ovf_add :
                      ((op_i == OP_SUB) || (op_i == OP_SLT)) ? w_ovf_sub : 1'b0;

    assign in_ready_o = ~rst_i & ((r_state == S_IDLE) ||
                                  ((r_state == S_DONE) && out_ready_i && ~kill_i));
    assign out_valid_o   = (r_state == S_DONE);
    assign w_take        = in_valid_i & in_ready_o & ~kill_i;
    assign w_start_shift = w_take & w_is_shift & (w_shamt != '0);

    // Each SHIFT cycle moves min(ShiftPerCycle, remaining) bit positions.
    assign w_step       = ({1'b0, r_rem} > LP_STEP) ? LP_STEP : {1'b0, r_rem};
    assign w_rem_next   = {1'b0, r_rem} - w_step;
    assign w_shift_last = (w_rem_next == '0);

    always_comb begin
        w_shifted = r_acc;
        case (r_kind)
            OP_SLL:  w_shifted = r_acc << w_step;
            OP_SRL:  w_shifted = r_acc >> w_step;
            default: w_shifted = $signed(r_acc) >>> w_step;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_take) begin
                    w_state_next = w_start_shift ? S_SHIFT : S_DONE;
                end
            end
            S_SHIFT: begin
                if (w_shift_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready_i) begin
                    if (w_take) begin
                        w_state_next = w_start_shift ? S_SHIFT : S_DONE;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
        if (kill_i) begin
            w_state_next = S_IDLE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Shift flags wait in r_pend_* so a kill mid-shift leaves the old outputs intact.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_acc      <= '0;
            r_rem      <= '0;
            r_kind     <= '0;
            r_pend_z   <= 1'b0;
            r_pend_n   <= 1'b0;
            r_pend_v   <= 1'b0;
            result_o   <= '0;
            zero_o     <= 1'b0;
            negative_o <= 1'b0;
            overflow_o <= 1'b0;
        end else if (!kill_i) begin
            if (w_take) begin
                if (w_start_shift) begin
                    r_acc    <= operand_a_i;
                    r_rem    <= w_shamt;
                    r_kind   <= op_i;
                    r_pend_z <= w_flag_z;
                    r_pend_n <= w_flag_n;
                    r_pend_v <= w_flag_v;
                end else begin
                    result_o   <= w_result;
                    zero_o     <= w_flag_z;
                    negative_o <= w_flag_n;
                    overflow_o <= w_flag_v;
                end
            end else if (r_state == S_SHIFT) begin
                r_acc <= w_shifted;
                r_rem <= w_rem_next[SW-1:0];
                if (w_shift_last) begin
                    result_o   <= w_shifted;
                    zero_o     <= r_pend_z;
                    negative_o <= r_pend_n;
                    overflow_o <= r_pend_v;
                end
            end
        end
    end

endmodule

// File: tb/tb_ristretto_alu_mc.sv
// Bench for ristretto_alu_mc: directed vector table, handshake/kill/reset sequences,
// and random operations checked against an arithmetic reference model.
module tb_ristretto_alu_mc;

    localparam int DW = 32;
    localparam int K  = 1;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    op;
    logic [DW-1:0] opa;
    logic [DW-1:0] opb;
    logic          kill;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] result;
    logic          zf;
    logic          nf;
    logic          vf;

    logic          in_valid8;
    logic          in_ready8;
    logic [3:0]    op8;
    logic [DW-1:0] opa8;
    logic [DW-1:0] opb8;
    logic          out_valid8;
    logic          out_ready8;
    logic [DW-1:0] result8;
    logic          zf8;
    logic          nf8;
    logic          vf8;

    int errors = 0;
    int checks = 0;

    logic [DW+2:0] exp_q[$];

    typedef struct {
        logic [3:0]    op;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] res;
        logic          z;
        logic          n;
        logic          v;
        int            lat;
    } vec_t;

    vec_t vecs[14];

    ristretto_alu_mc #(.DataWidth(DW), .ShiftPerCycle(K)) dut (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .op_i(op), .operand_a_i(opa), .operand_b_i(opb), .kill_i(kill),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .result_o(result),
        .zero_o(zf), .negative_o(nf), .overflow_o(vf)
    );

    ristretto_alu_mc #(.DataWidth(DW), .ShiftPerCycle(8)) dut8 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid8), .in_ready_o(in_ready8),
        .op_i(op8), .operand_a_i(opa8), .operand_b_i(opb8), .kill_i(1'b0),
        .out_valid_o(out_valid8), .out_ready_i(out_ready8), .result_o(result8),
        .zero_o(zf8), .negative_o(nf8), .overflow_o(vf8)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on whole words.
    function automatic vec_t model(input logic [3:0] m_op, input logic [DW-1:0] a,
                                   input logic [DW-1:0] b);
        vec_t r;
        longint sa;
        longint sb;
        longint sum;
        longint dif;
        int s;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sum = sa + sb;
        dif = sa - sb;
        s = int'(b[4:0]);
        r.op = m_op;
        r.a = a;
        r.b = b;
        r.lat = 1;
        case (m_op)
            4'd0: r.res = a + b;
            4'd1: r.res = a - b;
            4'd2: r.res = a & b;
            4'd3: r.res = a | b;
            4'd4: r.res = a ^ b;
            4'd5: r.res = (sa < sb) ? 1 : 0;
            4'd6: r.res = (a < b) ? 1 : 0;
            4'd7: r.res = a << s;
            4'd8: r.res = a >> s;
            4'd9: r.res = DW'(sa >>> s);
            default: r.res = a;
        endcase
        if ((m_op == 4'd7 || m_op == 4'd8 || m_op == 4'd9) && s != 0) begin
            r.lat = 1 + (s + K - 1) / K;
        end
        r.z = (a == b);
        r.n = (m_op == 4'd6 || m_op == 4'd8) ? (a < b) : (sa < sb);
        if (m_op == 4'd0) begin
            r.v = (sum > 64'sd2147483647) || (sum < -64'sd2147483648);
        end else if (m_op == 4'd1 || m_op == 4'd5) begin
            r.v = (dif > 64'sd2147483647) || (dif < -64'sd2147483648);
        end else begin
            r.v = 1'b0;
        end
        return r;
    endfunction

    // Driver: issue one op, measure latency, stall the output, then compare and retire.
    task automatic run_op(input vec_t e, input int stall, input string tag);
        int lat;
        int n;
        logic [DW+2:0] exp_item;
        logic [DW-1:0] held;
        in_valid = 1'b1;
        op = e.op;
        opa = e.a;
        opb = e.b;
        out_ready = 1'b0;
        #1;
        n = 0;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            check({tag, "_in_ready_timeout"}, {31'd0, in_ready}, 32'd1);
        end
        exp_q.push_back({e.res, e.z, e.n, e.v});
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, DW'(lat), DW'(e.lat));
        held = result;
        for (int i = 0; i < stall; i++) begin
            tick();
            if (result !== held || !out_valid || in_ready) begin
                check({tag, "_stall_stable"}, {result[DW-1:1], out_valid & ~in_ready},
                      {held[DW-1:1], 1'b1});
            end
        end
        exp_item = exp_q.pop_front();
        check({tag, "_result"}, result, exp_item[DW+2:3]);
        check({tag, "_flags"}, {29'd0, zf, nf, vf}, {29'd0, exp_item[2:0]});
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        int seen;
        vec_t e;
        in_valid = 1'b0;
        op = '0;
        opa = '0;
        opb = '0;
        kill = 1'b0;
        out_ready = 1'b0;
        in_valid8 = 1'b0;
        op8 = '0;
        opa8 = '0;
        opb8 = '0;
        out_ready8 = 1'b0;

        vecs[0]  = '{4'd0,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 1'b1, 1};
        vecs[1]  = '{4'd1,  32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1'b0, 1};
        vecs[2]  = '{4'd6,  32'h00000001, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b1, 1'b0, 1};
        vecs[3]  = '{4'd5,  32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0, 1'b0, 1};
        vecs[4]  = '{4'd9,  32'h80000000, 32'h0000001F, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 32};
        vecs[5]  = '{4'd7,  32'h00001234, 32'h00000000, 32'h00001234, 1'b0, 1'b0, 1'b0, 1};
        vecs[6]  = '{4'd2,  32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0, 1'b1, 1'b0, 1};
        vecs[7]  = '{4'd3,  32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, 1'b0, 1'b1, 1'b0, 1};
        vecs[8]  = '{4'd4,  32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00, 1'b0, 1'b1, 1'b0, 1};
        vecs[9]  = '{4'd8,  32'h80000000, 32'h00000004, 32'h08000000, 1'b0, 1'b0, 1'b0, 5};
        vecs[10] = '{4'd12, 32'hDEADBEEF, 32'h00000001, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 1};
        vecs[11] = '{4'd1,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b1, 1};
        vecs[12] = '{4'd7,  32'h00000001, 32'h00000025, 32'h00000020, 1'b0, 1'b1, 1'b0, 6};
        vecs[13] = '{4'd5,  32'h80000000, 32'h00000001, 32'h00000001, 1'b0, 1'b1, 1'b1, 1};

        // Reset
        rst = 1'b1;
        tick();
        tick();
        check("reset_in_ready", {31'd0, in_ready}, 32'd0);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_result", result, 32'd0);
        check("reset_flags", {29'd0, zf, nf, vf}, 32'd0);
        rst = 1'b0;
        #1;
        check("idle_in_ready", {31'd0, in_ready}, 32'd1);
        tick();

        // Directed table
        for (int i = 0; i < 14; i++) begin
            run_op(vecs[i], i % 3, $sformatf("vec%0d", i));
        end

        // Backpressure then back-to-back issue
        e = '{4'd0, 32'd3, 32'd4, 32'd7, 1'b0, 1'b1, 1'b0, 1};
        in_valid = 1'b1; op = e.op; opa = e.a; opb = e.b; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        check("bp_valid", {31'd0, out_valid}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("bp_hold", {result[30:0], out_valid}, {31'd7, 1'b1});
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b1; op = 4'd0; opa = 32'd10; opb = 32'd20; out_ready = 1'b1;
        #1;
        check("b2b_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        check("b2b_valid", {31'd0, out_valid}, 32'd1);
        check("b2b_result", result, 32'd30);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Kill during third SHIFT cycle of a 31-bit SRL
        in_valid = 1'b1; op = 4'd8; opa = 32'hFFFFFFFF; opb = 32'd31;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        kill = 1'b1;
        tick();
        kill = 1'b0;
        check("kill_valid", {31'd0, out_valid}, 32'd0);
        check("kill_idle", {31'd0, in_ready}, 32'd1);
        check("kill_result_kept", result, 32'd30);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (out_valid) seen++;
        end
        check("kill_no_valid", seen, 0);

        // Kill in DONE outranks out_ready and a pending request
        in_valid = 1'b1; op = 4'd0; opa = 32'd1; opb = 32'd1;
        tick();
        in_valid = 1'b1; op = 4'd0; opa = 32'd5; opb = 32'd5;
        kill = 1'b1; out_ready = 1'b1;
        #1;
        check("kill_done_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        kill = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        check("kill_done_valid", {31'd0, out_valid}, 32'd0);
        check("kill_done_result", result, 32'd2);
        tick();
        check("kill_done_no_accept", {31'd0, out_valid}, 32'd0);

        // Reset mid-SHIFT
        in_valid = 1'b1; op = 4'd9; opa = 32'h80000000; opb = 32'd31;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("rst_mid_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        check("rst_mid_outputs", {result[28:0], out_valid, zf, nf | vf}, 32'd0);
        rst = 1'b0;
        tick();
        check("rst_mid_stays_idle", {31'd0, out_valid}, 32'd0);

        // ShiftPerCycle=8 instance: SRA by 31
        in_valid8 = 1'b1; op8 = 4'd9; opa8 = 32'h80000000; opb8 = 32'd31;
        #1;
        check("spc8_in_ready", {31'd0, in_ready8}, 32'd1);
        tick();
        in_valid8 = 1'b0;
        seen = 1;
        while (!out_valid8 && seen < 100) begin
            tick();
            seen++;
        end
        check("spc8_latency", seen, 5);
        check("spc8_result", result8, 32'hFFFFFFFF);
        check("spc8_flags", {29'd0, zf8, nf8, vf8}, 32'd2);
        out_ready8 = 1'b1;
        tick();
        out_ready8 = 1'b0;

        // Random operations against the model
        for (int i = 0; i < 200; i++) begin
            logic [3:0] r_op;
            logic [DW-1:0] ra;
            logic [DW-1:0] rb;
            r_op = 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = ra;
                1: ra = 32'h80000000 ^ 32'($urandom_range(0, 3));
                2: rb = 32'h7FFFFFFF - 32'($urandom_range(0, 3));
                default: ;
            endcase
            run_op(model(r_op, ra, rb), $urandom_range(0, 3), $sformatf("rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
